// File: rtl/ttl_cen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ttl_cen_sequencer
//  Description : Multi-channel clock-enable generator; each Cen falling edge
//                is the emulated clock edge for synchronous TTL models.
//  Revision    : 1.0
// ============================================================================
module ttl_cen_sequencer #(
    parameter int CHANNELS  = 2,
    parameter int DIVW      = 8,
    parameter int DIV_RESET = 1
) (
    input  logic                                               Clk,
    input  logic                                               RST,
    input  logic                                               Run,
    input  logic                                               Resync,
    input  logic                                               CfgValid,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] CfgCh,
    input  logic [DIVW-1:0]                                    CfgDiv,
    output logic                                               CfgReady,
    output logic [CHANNELS-1:0]                                Cen,
    output logic [CHANNELS-1:0]                                Fall
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [DIVW-1:0] c_div_reset = DIVW'(DIV_RESET);

    logic [CHANNELS-1:0][1:0]      r_state;
    logic [CHANNELS-1:0][DIVW-1:0] r_cnt;
    logic [CHANNELS-1:0][DIVW-1:0] r_div;
    logic [CHANNELS-1:0][DIVW-1:0] r_pdiv;
    logic [CHANNELS-1:0]           r_pend;
    logic [CHANNELS-1:0]           r_cen;
    logic [CHANNELS-1:0]           r_fall;
    logic                          r_ready;

    logic [CHANNELS-1:0][1:0]      w_state_n;
    logic [CHANNELS-1:0][DIVW-1:0] w_cnt_n;
    logic [CHANNELS-1:0][DIVW-1:0] w_div_n;
    logic [CHANNELS-1:0][DIVW-1:0] w_pdiv_n;
    logic [CHANNELS-1:0][DIVW-1:0] w_ndiv;
    logic [CHANNELS-1:0]           w_pend_n;
    logic [CHANNELS-1:0]           w_cen_n;
    logic [CHANNELS-1:0]           w_fall_n;
    logic [CHANNELS-1:0]           w_apply;
    logic [CHANNELS-1:0]           w_take;
    logic                          w_xfer;
    logic                          w_resync;

    always_comb begin
        w_xfer    = CfgValid & r_ready;
        w_resync  = Resync & Run;
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_div_n   = r_div;
        w_pdiv_n  = r_pdiv;
        w_pend_n  = r_pend;
        w_cen_n   = r_cen;
        w_fall_n  = '0;
        w_apply   = '0;
        w_take    = '0;
        w_ndiv    = r_div;
        for (int i = 0; i < CHANNELS; i++) begin
            // Divider that a reload at this edge would use
            w_ndiv[i] = r_pend[i] ? r_pdiv[i] : r_div[i];
            w_take[i] = w_xfer && (CfgCh == CHW'(i));
            if (w_resync) begin
                w_state_n[i] = S_HIGH;
                w_cnt_n[i]   = w_ndiv[i];
                w_cen_n[i]   = 1'b1;
                w_apply[i]   = 1'b1;
            end else begin
                case (r_state[i])
                    S_IDLE: begin
                        w_cen_n[i] = 1'b1;
                        w_apply[i] = 1'b1;
                        if (Run) begin
                            w_state_n[i] = S_HIGH;
                            w_cnt_n[i]   = w_ndiv[i];
                        end
                    end
                    S_HIGH: begin
                        if (!Run) begin
                            w_state_n[i] = S_IDLE;
                        end else if (r_cnt[i] != '0) begin
                            w_cnt_n[i] = r_cnt[i] - DIVW'(1);
                        end else begin
                            w_state_n[i] = S_LOW;
                            w_cnt_n[i]   = w_ndiv[i];
                            w_cen_n[i]   = 1'b0;
                            w_fall_n[i]  = 1'b1;
                            w_apply[i]   = 1'b1;
                        end
                    end
                    S_LOW: begin
                        // A low phase always runs to completion, even if Run drops
                        if (r_cnt[i] != '0) begin
                            w_cnt_n[i] = r_cnt[i] - DIVW'(1);
                        end else if (!Run) begin
                            w_state_n[i] = S_IDLE;
                            w_cen_n[i]   = 1'b1;
                        end else begin
                            w_state_n[i] = S_HIGH;
                            w_cnt_n[i]   = w_ndiv[i];
                            w_cen_n[i]   = 1'b1;
                            w_apply[i]   = 1'b1;
                        end
                    end
                    default: begin
                        w_state_n[i] = S_IDLE;
                        w_cen_n[i]   = 1'b1;
                    end
                endcase
            end
            if (w_apply[i]) begin
                w_div_n[i]  = w_ndiv[i];
                w_pend_n[i] = 1'b0;
            end
            if (w_take[i]) begin
                w_pdiv_n[i] = CfgDiv;
                w_pend_n[i] = 1'b1;
            end
        end
    end

    // Only one transfer can be outstanding, so ready simply means nothing pending
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            r_state <= {CHANNELS{S_IDLE}};
            r_cnt   <= '0;
            r_div   <= {CHANNELS{c_div_reset}};
            r_pdiv  <= {CHANNELS{c_div_reset}};
            r_pend  <= '0;
            r_cen   <= '1;
            r_fall  <= '0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_div   <= w_div_n;
            r_pdiv  <= w_pdiv_n;
            r_pend  <= w_pend_n;
            r_cen   <= w_cen_n;
            r_fall  <= w_fall_n;
            r_ready <= ~|w_pend_n;
        end
    end

    assign Cen      = r_cen;
    assign Fall     = r_fall;
    assign CfgReady = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_ttl_cen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ttl_cen_sequencer
//  Description : Directed and randomized checks of ttl_cen_sequencer against
//                a phase-length reference model.
//  Revision    : 1.0
// ============================================================================
module tb_ttl_cen_sequencer;

    localparam int CH = 2;

    logic       Clk;
    logic       RST;
    logic       Run;
    logic       Resync;
    logic       CfgValid;
    logic [0:0] CfgCh;
    logic [7:0] CfgDiv;
    logic       CfgReady;
    logic [1:0] Cen;
    logic [1:0] Fall;

    int tests;
    int failures;

    // Reference model: each phase has a fixed length div+1 chosen on entry
    int         m_mode [CH];   // 0 idle, 1 high, 2 low
    int         m_age  [CH];
    int         m_len  [CH];
    int         m_div  [CH];
    int         m_pdiv [CH];
    bit         m_pend [CH];
    logic [1:0] m_cen;
    logic [1:0] m_fall;
    logic       m_ready;

    ttl_cen_sequencer #(.CHANNELS(2), .DIVW(8), .DIV_RESET(1)) dut (
        .Clk      (Clk),
        .RST      (RST),
        .Run      (Run),
        .Resync   (Resync),
        .CfgValid (CfgValid),
        .CfgCh    (CfgCh),
        .CfgDiv   (CfgDiv),
        .CfgReady (CfgReady),
        .Cen      (Cen),
        .Fall     (Fall)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0; m_age[c] = 0; m_len[c] = 0;
            m_div[c] = 1;  m_pdiv[c] = 1; m_pend[c] = 1'b0;
        end
        m_cen = 2'b11; m_fall = 2'b00; m_ready = 1'b1;
    endtask

    task automatic enter_phase(int c, int mode, int d);
        m_mode[c] = mode; m_age[c] = 0; m_len[c] = d + 1;
        m_div[c] = d; m_pend[c] = 1'b0;
        m_cen[c] = (mode == 1);
    endtask

    task automatic model_edge();
        bit xfer;
        bit any;
        int nd;
        xfer = CfgValid && m_ready;
        for (int c = 0; c < CH; c++) begin
            m_fall[c] = 1'b0;
            nd = m_pend[c] ? m_pdiv[c] : m_div[c];
            if (Run && Resync) begin
                enter_phase(c, 1, nd);
            end else if (m_mode[c] == 0) begin
                m_div[c] = nd; m_pend[c] = 1'b0;
                if (Run) enter_phase(c, 1, nd);
            end else if (m_mode[c] == 1) begin
                if (!Run) m_mode[c] = 0;
                else begin
                    m_age[c]++;
                    if (m_age[c] == m_len[c]) begin
                        enter_phase(c, 2, nd);
                        m_fall[c] = 1'b1;
                    end
                end
            end else begin
                m_age[c]++;
                if (m_age[c] == m_len[c]) begin
                    if (!Run) begin m_mode[c] = 0; m_cen[c] = 1'b1; end
                    else enter_phase(c, 1, nd);
                end
            end
            if (xfer && int'(CfgCh) == c) begin
                m_pdiv[c] = int'(CfgDiv); m_pend[c] = 1'b1;
            end
        end
        any = 1'b0;
        for (int c = 0; c < CH; c++) any |= m_pend[c];
        m_ready = !any;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check("cen", 32'(Cen), 32'(m_cen));
        check("fall", 32'(Fall), 32'(m_fall));
        check("ready", 32'(CfgReady), 32'(m_ready));
    endtask

    task automatic cfg_write(int ch, int d);
        int k;
        CfgValid = 1'b1; CfgCh = 1'(ch); CfgDiv = 8'(d);
        tick();
        CfgValid = 1'b0;
        k = 0;
        while (CfgReady !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("cfg_wait", 32'(k < 40), 32'd1);
    endtask

    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_cen", 32'(Cen), 32'h3);
        check("rst_fall", 32'(Fall), 32'h0);
        check("rst_ready", 32'(CfgReady), 32'h1);
        @(posedge Clk);
        #1;
        RST = 1'b0;
        check("rst_hold_cen", 32'(Cen), 32'h3);
    endtask

    logic [7:0] rec0, rec1, recf0;
    logic [3:0] rec4;

    initial begin
        tests = 0; failures = 0;
        RST = 1'b1; Run = 1'b0; Resync = 1'b0;
        CfgValid = 1'b0; CfgCh = '0; CfgDiv = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_cen", 32'(Cen), 32'h3);
        check("reset_fall", 32'(Fall), 32'h0);
        check("reset_ready", 32'(CfgReady), 32'h1);
        RST = 1'b0;
        repeat (2) tick();

        // div0=2, div1=0, then start both channels together
        cfg_write(0, 2);
        cfg_write(1, 0);
        Run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            rec0[k] = Cen[0]; rec1[k] = Cen[1]; recf0[k] = Fall[0];
        end
        check("start_cen0", 32'(rec0), 32'hC7);
        check("start_cen1", 32'(rec1), 32'h55);
        check("start_fall0", 32'(recf0), 32'h08);

        // Reset arriving mid-LOW must raise Cen without a clock edge
        repeat (2) tick();
        check("pre_rst_low", 32'(Cen[0]), 32'h0);
        async_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            rec4[k] = Cen[0];
        end
        check("post_rst_div", 32'(rec4), 32'h3);

        for (int n = 0; n < 2500; n++) begin
            Run      = ($urandom_range(0, 15) != 0);
            Resync   = ($urandom_range(0, 29) == 0);
            CfgValid = ($urandom_range(0, 3) == 0);
            CfgCh    = 1'($urandom_range(0, 1));
            CfgDiv   = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ttl_cen_sequencer.md
TTL_CEN_SEQUENCER -- requirements
Module: ttl_cen_sequencer

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent clock-enable channels.
REQ-002 Parameter DIVW, default 8: divider width in bits.
REQ-003 Parameter DIV_RESET, default 1: divider value loaded into every channel on reset.
REQ-004 Clk  in  1  sole clock; all logic on posedge Clk.
REQ-005 RST  in  1  reset, asynchronous and active-high.
REQ-006 Run  in  1  level; 1 = channels generate Cen waveforms.
REQ-007 Resync  in  1  single-cycle pulse; phase-aligns all running channels.
REQ-008 CfgValid  in  1  config request.
REQ-009 CfgCh  in  CHW  target channel index; CHW = max(1, clog2(CHANNELS)).
REQ-010 CfgDiv  in  DIVW  new divider value.
REQ-011 CfgReady  out  1  registered; 1 = config can be accepted.
REQ-012 Cen  out  CHANNELS  registered clock-enable waveforms; the high-to-low transition is the emulated clock edge for the synchronous TTL flip-flop models.
REQ-013 Fall  out  CHANNELS  registered one-cycle strobe, high in the first cycle Cen[i] is 0 after being 1.

Function
REQ-014 Each channel SHALL hold state IDLE/HIGH/LOW, a DIVW-bit down-counter cnt, an active divider div, a pending divider pdiv and a pending flag pend.
REQ-015 IDLE: Cen=1; if Run=1, go to HIGH next cycle with cnt=div.
REQ-016 HIGH: Cen=1; cnt!=0 -> cnt-1; cnt==0 -> LOW, cnt=div, Cen=0, Fall=1 for that cycle.
REQ-017 LOW: Cen=0; cnt!=0 -> cnt-1; cnt==0 -> HIGH, cnt=div, Cen=1.
REQ-018 Waveform SHALL be Cen high for div+1 cycles, then low for div+1 cycles; period 2*(div+1); div=0 gives a 1-cycle-high/1-cycle-low alternation.
REQ-019 Latency: Run sampled 1 at edge t -> Cen stays 1; the first Cen 0 and the first Fall occur in cycle t+2+div.
REQ-020 Run=0 in HIGH: go to IDLE next cycle, with no Cen change.
REQ-021 Run=0 in LOW: complete the LOW phase, then go to IDLE instead of HIGH; no truncated low pulse.
REQ-022 Config handshake: a transfer occurs when CfgValid=1 and CfgReady=1 at a posedge.
REQ-023 On a transfer, pdiv[CfgCh] SHALL take CfgDiv and pend[CfgCh] SHALL be set.
REQ-024 CfgCh >= CHANNELS: the transfer is accepted and discarded.
REQ-025 CfgReady SHALL be 0 from the cycle after a transfer until the pend flag set by that transfer clears; otherwise 1.
REQ-026 Pending divider SHALL be applied at the channel's next reload point: div=pdiv and pend cleared.
REQ-027 Reload points are the HIGH->LOW transition, the LOW->HIGH transition, IDLE->HIGH entry, or any cycle spent in IDLE.
REQ-028 When pending is applied at a transition, the reloaded cnt SHALL use the new value.
REQ-029 A phase already in progress SHALL never be shortened or lengthened by a config change.
REQ-030 Resync=1 with Run=1: every non-IDLE channel enters HIGH next cycle with cnt=div and Cen=1; no Fall is generated.
REQ-031 Resync=1 with Run=1: IDLE channels behave per REQ-015.
REQ-032 Resync=1 with Run=1: pending dividers are applied at the same edge.
REQ-033 Resync with Run=0 SHALL be ignored.
REQ-034 Priority SHALL be RST > Resync > Run-stop > normal counting.
REQ-035 Channels SHALL be independent except for the shared Resync, Run and config port.

Reset
REQ-036 RST=1 SHALL immediately force all channels to IDLE: Cen all 1, Fall all 0, cnt=0, div=DIV_RESET, pend=0, pdiv=DIV_RESET, CfgReady=1.
REQ-037 RST asserted mid-phase SHALL abort the phase with no Fall strobe.
REQ-038 After RST deasserts, operation SHALL resume per REQ-015 on the first posedge with Run=1.

Verification
REQ-039 Run=1, div0=0: Cen[0]=1,0,1,0...; Fall[0] pulses every 2nd cycle, coincident with Cen[0]=0.
REQ-040 div0=2, div1=0, Run rises at edge t: Cen[0] first low at t+4 for 3 cycles; Cen[1] first low at t+2; both stay periodic.
REQ-041 div0=3 running; transfer CfgCh=0, CfgDiv=1 mid-HIGH: HIGH completes 4 cycles, LOW lasts 2; CfgReady=0 until that transition, then 1.
REQ-042 Run dropped during LOW of a div=3 channel: Cen stays 0 for the full 4-cycle phase, then 1 in IDLE; no further Fall.
REQ-043 Channels at div=1 and div=2 out of phase; Resync pulse: both Cen=1 next cycle; first Fall at +3 and +4 cycles respectively.
REQ-044 RST pulsed mid-LOW: Cen returns to 1 without waiting for a clock edge; div=DIV_RESET; CfgReady=1.
